// File: rtl/clock_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : clock_pkg
//  Description : Shared encodings for the multimodal digital clock: the
//                front-panel mode codes and the stopwatch / timer state
//                enumerations used by the sequencing controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package clock_pkg;

    // Front-panel mode codes, also used directly as the display mux select.
    localparam logic [1:0] MODE_SET   = 2'b00;
    localparam logic [1:0] MODE_CLK24 = 2'b01;
    localparam logic [1:0] MODE_SW    = 2'b10;
    localparam logic [1:0] MODE_TMR   = 2'b11;

    // Countdown timer sequencing states.
    typedef enum logic [1:0] {
        T_IDLE  = 2'd0,
        T_RUN   = 2'd1,
        T_PAUSE = 2'd2,
        T_ALARM = 2'd3
    } tmr_state_t;

    // Stopwatch run/stop state.
    typedef enum logic {
        SW_STOP = 1'b0,
        SW_RUN  = 1'b1
    } sw_state_t;

endpackage : clock_pkg
`default_nettype wire

// File: rtl/mode_ctrl_timer.sv
`default_nettype none
// ============================================================================
//  Module      : timer_ctrl
//  Description : Countdown timer sequencer. Runs the idle/run/pause/alarm
//                state machine, generates the per-second decrement enable
//                and preset load strobe for the timer datapath, and holds
//                the expiry alarm for ALARM_SECS ticks.
//
//  Ports
//    clk         in   system clock
//    reset       in   asynchronous active-high reset
//    tick_1hz    in   one-cycle pulse per second
//    load_tmr    in   load pulse, already qualified by timer mode
//    ss_tmr      in   start/stop pulse, already qualified by timer mode
//    ss_any      in   raw start/stop pulse (acknowledges alarm in any mode)
//    timer_zero  in   timer datapath reads 00:00:00
//    tmr_en      out  registered decrement enable (one cycle)
//    tmr_load    out  registered preset load strobe (one cycle)
//    alarm       out  registered expiry level
//
//  Revision    : 1.0 - initial release
// ============================================================================
module timer_ctrl
    import clock_pkg::*;
#(
    parameter int ALARM_SECS = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic tick_1hz,
    input  logic load_tmr,
    input  logic ss_tmr,
    input  logic ss_any,
    input  logic timer_zero,
    output logic tmr_en,
    output logic tmr_load,
    output logic alarm
);

    localparam logic [2:0] ALARM_INIT = 3'(ALARM_SECS);

    tmr_state_t state;
    logic [2:0] alarm_cnt;

    // Outputs are registered alongside the state. The alarm level is set on
    // the edge that enters T_ALARM and cleared on every edge that leaves it,
    // so it is always equal to (state == T_ALARM).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= T_IDLE;
            alarm_cnt <= 3'd0;
            tmr_en    <= 1'b0;
            tmr_load  <= 1'b0;
            alarm     <= 1'b0;
        end else begin
            // Enable follows the pre-transition state, but never decrements
            // past zero even on the cycle the expiry is detected.
            tmr_en   <= tick_1hz && (state == T_RUN) && !timer_zero;
            tmr_load <= 1'b0;

            case (state)
                T_IDLE: begin
                    if (load_tmr) begin
                        tmr_load <= 1'b1;
                    end
                    // Starting from zero would expire immediately; ignore it.
                    if (ss_tmr && !timer_zero) begin
                        state <= T_RUN;
                    end
                end

                T_RUN: begin
                    // Expiry takes priority over a coincident pause request.
                    if (timer_zero) begin
                        state     <= T_ALARM;
                        alarm_cnt <= ALARM_INIT;
                        alarm     <= 1'b1;
                    end else if (ss_tmr) begin
                        state <= T_PAUSE;
                    end
                end

                T_PAUSE: begin
                    if (load_tmr) begin
                        tmr_load <= 1'b1;
                        state    <= T_IDLE;
                    end else if (ss_tmr && !timer_zero) begin
                        state <= T_RUN;
                    end
                end

                T_ALARM: begin
                    if (ss_any) begin
                        state     <= T_IDLE;
                        alarm_cnt <= 3'd0;
                        alarm     <= 1'b0;
                    end else if (load_tmr) begin
                        tmr_load  <= 1'b1;
                        state     <= T_IDLE;
                        alarm_cnt <= 3'd0;
                        alarm     <= 1'b0;
                    end else if (tick_1hz) begin
                        // A count of zero can only come from a bad parameter;
                        // treat it like the last second so the alarm cannot stick.
                        if (alarm_cnt <= 3'd1) begin
                            state     <= T_IDLE;
                            alarm_cnt <= 3'd0;
                            alarm     <= 1'b0;
                        end else begin
                            alarm_cnt <= alarm_cnt - 3'd1;
                        end
                    end
                end

                default: begin
                    state     <= T_IDLE;
                    alarm_cnt <= 3'd0;
                    alarm     <= 1'b0;
                end
            endcase
        end
    end

endmodule : timer_ctrl
`default_nettype wire

// File: rtl/mode_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mode_ctrl
//  Description : Sequencing controller for the multimodal digital clock.
//                Registers the selected mode, gates the 1 Hz tick into the
//                clock24 / stopwatch / timer count enables, issues load and
//                clear strobes, and runs the stopwatch state machine. The
//                timer state machine and alarm live in timer_ctrl.
//
//  Ports
//    clk         in   system clock
//    reset       in   asynchronous active-high reset
//    mode[1:0]   in   requested mode (00 set, 01 clock24, 10 stopwatch, 11 timer)
//    tick_1hz    in   one-cycle pulse per second
//    load        in   debounced load pulse
//    start_stop  in   debounced start/stop pulse
//    clear       in   debounced clear pulse
//    timer_zero  in   timer datapath reads zero
//    disp_sel    out  display mux select (registered mode)
//    clk24_en    out  clock24 count enable
//    clk24_load  out  clock24 preset load strobe
//    sw_en       out  stopwatch count enable
//    sw_clear    out  stopwatch clear strobe
//    tmr_en      out  timer decrement enable
//    tmr_load    out  timer preset load strobe
//    alarm       out  timer expired level
//
//  Revision    : 1.0 - initial release
// ============================================================================
module mode_ctrl
    import clock_pkg::*;
#(
    parameter int ALARM_SECS = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] mode,
    input  logic       tick_1hz,
    input  logic       load,
    input  logic       start_stop,
    input  logic       clear,
    input  logic       timer_zero,
    output logic [1:0] disp_sel,
    output logic       clk24_en,
    output logic       clk24_load,
    output logic       sw_en,
    output logic       sw_clear,
    output logic       tmr_en,
    output logic       tmr_load,
    output logic       alarm
);

    logic [1:0] mode_q;
    sw_state_t  sw_state;

    // Buttons are qualified by the registered mode, so a press arriving in
    // the same cycle as a mode change still acts on the previous mode.
    logic in_set;
    logic in_sw;
    logic in_tmr;
    logic load_tmr;
    logic ss_tmr;

    assign in_set   = (mode_q == MODE_SET);
    assign in_sw    = (mode_q == MODE_SW);
    assign in_tmr   = (mode_q == MODE_TMR);
    assign load_tmr = load && in_tmr;
    assign ss_tmr   = start_stop && in_tmr;

    assign disp_sel = mode_q;

    // ------------------------------------------------------------------------
    // Mode register and clock24 gating. The clock is frozen while being set.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q     <= MODE_CLK24;
            clk24_en   <= 1'b0;
            clk24_load <= 1'b0;
        end else begin
            mode_q     <= mode;
            clk24_en   <= tick_1hz && !in_set;
            clk24_load <= load && in_set;
        end
    end

    // ------------------------------------------------------------------------
    // Stopwatch FSM. It keeps counting while another mode is displayed; only
    // its buttons are restricted to stopwatch mode. The enable is taken from
    // the pre-transition state, so the tick that coincides with a start does
    // not count.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw_state <= SW_STOP;
            sw_en    <= 1'b0;
            sw_clear <= 1'b0;
        end else begin
            sw_en    <= tick_1hz && (sw_state == SW_RUN);
            sw_clear <= clear && in_sw;

            if (in_sw) begin
                // Clear wins over a coincident start/stop.
                if (clear) begin
                    sw_state <= SW_STOP;
                end else if (start_stop) begin
                    sw_state <= (sw_state == SW_RUN) ? SW_STOP : SW_RUN;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Countdown timer sequencer.
    // ------------------------------------------------------------------------
    timer_ctrl #(
        .ALARM_SECS (ALARM_SECS)
    ) u_timer_ctrl (
        .clk        (clk),
        .reset      (reset),
        .tick_1hz   (tick_1hz),
        .load_tmr   (load_tmr),
        .ss_tmr     (ss_tmr),
        .ss_any     (start_stop),
        .timer_zero (timer_zero),
        .tmr_en     (tmr_en),
        .tmr_load   (tmr_load),
        .alarm      (alarm)
    );

endmodule : mode_ctrl
`default_nettype wire
